// File: rtl/vga_digit_display_if.sv
// Pixel write channel from the classifier into the digit display.
// The master offers 4-bit grayscale pixels in raster order; the slave accepts them with wr_ready.
interface vga_digit_display_if;
    logic       wr_valid;
    logic [3:0] wr_data;
    logic       wr_ready;

    modport master (
        output wr_valid,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/vga_digit_display.sv
// Double-buffered 28x28 grayscale digit overlay for a VGA raster, scaled by 2^SCALE_LOG2.
// Optional feature: define DIGIT_BORDER_EN to draw a 2-pixel white frame around the window.
module vga_digit_display #(
    parameter int ORIGIN_X   = 208,
    parameter int ORIGIN_Y   = 128,
    parameter int SCALE_LOG2 = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 h_active,
    input  logic                 v_active,
    input  logic [10:0]          h_pos,
    input  logic [10:0]          v_pos,
    vga_digit_display_if.slave   wr,
    output logic                 frame_done,
    output logic [7:0]           vga_rgb
);

    localparam int          DIGIT_DIM  = 28;
    localparam int          NUM_PIX    = DIGIT_DIM * DIGIT_DIM;
    localparam logic [9:0]  LAST_ADDR  = 10'(NUM_PIX - 1);
    localparam logic [10:0] WIN_SIZE   = 11'(DIGIT_DIM << SCALE_LOG2);
    localparam logic [10:0] ORIGIN_X_W = 11'(ORIGIN_X);
    localparam logic [10:0] ORIGIN_Y_W = 11'(ORIGIN_Y);
`ifdef DIGIT_BORDER_EN
    localparam logic [10:0] BORDER_W   = 11'd2;
`endif

    // Spread a 4-bit gray level over the 3-3-2 RGB channels.
    function automatic logic [7:0] gray_to_rgb(input logic [3:0] g);
        gray_to_rgb = {g[3:1], g[3:1], g[3:2]};
    endfunction

    // Buffer storage; contents are intentionally not reset.
    logic [3:0] mem0 [0:NUM_PIX-1];
    logic [3:0] mem1 [0:NUM_PIX-1];

    // Write-side state.
    logic [9:0] wr_addr_r;
    logic       disp_sel_r;
    logic       swap_pending_r;
    logic       wr_ready_r;
    logic       v_active_d_r;
    logic       frame_done_r;

    logic       accept_s;
    logic       last_word_s;
    logic       v_fall_s;
    logic       swap_s;
    logic [9:0] wr_addr_next_s;
    logic       swap_pending_next_s;
    logic       wr_ready_next_s;
    logic       disp_sel_next_s;

    // Display pipeline.
    logic [10:0] dx_s;
    logic [10:0] dy_s;
    logic [10:0] col_full_s;
    logic [10:0] row_full_s;
    logic [4:0]  col_s;
    logic [4:0]  row_s;
    logic        active_s;
    logic        in_win_s;
    logic [9:0]  rd_addr_s;
    logic        active_r;
    logic        in_win_r;
    logic [9:0]  rd_addr_r;
    logic [3:0]  rd_data_s;
    logic [7:0]  rgb_next_s;
    logic [7:0]  vga_rgb_r;
`ifdef DIGIT_BORDER_EN
    logic [10:0] bx_s;
    logic [10:0] by_s;
    logic        border_s;
    logic        border_r;
`endif

    assign wr.wr_ready = wr_ready_r;
    assign frame_done  = frame_done_r;
    assign vga_rgb     = vga_rgb_r;

    // Write handshake, frame wrap and buffer swap decisions.
    always_comb begin
        accept_s            = wr.wr_valid && wr_ready_r;
        last_word_s         = accept_s && (wr_addr_r == LAST_ADDR);
        v_fall_s            = v_active_d_r && !v_active;
        // swap_pending is the registered value, so a frame completing on the falling edge waits a frame.
        swap_s              = v_fall_s && swap_pending_r;
        wr_addr_next_s      = wr_addr_r;
        swap_pending_next_s = swap_pending_r;
        disp_sel_next_s     = disp_sel_r;
        if (accept_s) begin
            if (last_word_s) begin
                wr_addr_next_s = 10'd0;
            end else begin
                wr_addr_next_s = wr_addr_r + 10'd1;
            end
        end else begin
            wr_addr_next_s = wr_addr_r;
        end
        if (swap_s) begin
            swap_pending_next_s = 1'b0;
            disp_sel_next_s     = !disp_sel_r;
        end else if (last_word_s) begin
            swap_pending_next_s = 1'b1;
            disp_sel_next_s     = disp_sel_r;
        end else begin
            swap_pending_next_s = swap_pending_r;
            disp_sel_next_s     = disp_sel_r;
        end
        wr_ready_next_s = !swap_pending_next_s;
    end

    // Write-side state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr_r      <= 10'd0;
            disp_sel_r     <= 1'b0;
            swap_pending_r <= 1'b0;
            wr_ready_r     <= 1'b0;
            v_active_d_r   <= 1'b0;
            frame_done_r   <= 1'b0;
        end else begin
            wr_addr_r      <= wr_addr_next_s;
            disp_sel_r     <= disp_sel_next_s;
            swap_pending_r <= swap_pending_next_s;
            wr_ready_r     <= wr_ready_next_s;
            v_active_d_r   <= v_active;
            frame_done_r   <= swap_s;
        end
    end

    // Back-buffer write port.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            if (disp_sel_r) begin
                mem0[wr_addr_r] <= wr.wr_data;
            end else begin
                mem1[wr_addr_r] <= wr.wr_data;
            end
        end
    end

    // Window hit test and source address; the unsigned wrap rejects left/above coordinates.
    always_comb begin
        active_s   = h_active && v_active;
        dx_s       = h_pos - ORIGIN_X_W;
        dy_s       = v_pos - ORIGIN_Y_W;
        in_win_s   = (dx_s < WIN_SIZE) && (dy_s < WIN_SIZE);
        col_full_s = dx_s >> SCALE_LOG2;
        row_full_s = dy_s >> SCALE_LOG2;
        col_s      = col_full_s[4:0];
        row_s      = row_full_s[4:0];
        if (in_win_s) begin
            rd_addr_s = (10'(row_s) * 10'd28) + 10'(col_s);
        end else begin
            rd_addr_s = 10'd0;
        end
    end

`ifdef DIGIT_BORDER_EN
    // Ring of BORDER_W pixels around the window, excluding the window itself.
    always_comb begin
        bx_s     = h_pos - (ORIGIN_X_W - BORDER_W);
        by_s     = v_pos - (ORIGIN_Y_W - BORDER_W);
        border_s = (bx_s < (WIN_SIZE + (BORDER_W << 1)))
                && (by_s < (WIN_SIZE + (BORDER_W << 1)))
                && !in_win_s;
    end
`endif

    // Stage 1: register flags and read address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_r  <= 1'b0;
            in_win_r  <= 1'b0;
            rd_addr_r <= 10'd0;
`ifdef DIGIT_BORDER_EN
            border_r  <= 1'b0;
`endif
        end else begin
            active_r  <= active_s;
            in_win_r  <= in_win_s;
            rd_addr_r <= rd_addr_s;
`ifdef DIGIT_BORDER_EN
            border_r  <= border_s;
`endif
        end
    end

    // Display-buffer read and colour selection.
    always_comb begin
        if (disp_sel_r) begin
            rd_data_s = mem1[rd_addr_r];
        end else begin
            rd_data_s = mem0[rd_addr_r];
        end
        rgb_next_s = 8'h00;
        if (active_r && in_win_r) begin
            rgb_next_s = gray_to_rgb(rd_data_s);
        end
`ifdef DIGIT_BORDER_EN
        else if (active_r && border_r) begin
            rgb_next_s = 8'hFF;
        end
`endif
        else begin
            rgb_next_s = 8'h00;
        end
    end

    // Stage 2: registered pixel output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_rgb_r <= 8'h00;
        end else begin
            vga_rgb_r <= rgb_next_s;
        end
    end

endmodule

// File: tb/tb_vga_digit_display.sv
// Directed self-checking bench for vga_digit_display: reset, swap handshake,
// backpressure, scaling, blanking, window edges and the optional border.
module tb_vga_digit_display;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        h_active = 1'b0;
    logic        v_active = 1'b0;
    logic [10:0] h_pos = 11'd0;
    logic [10:0] v_pos = 11'd0;
    logic        frame_done;
    logic [7:0]  vga_rgb;

    int n_checks = 0;
    int n_pass   = 0;

    vga_digit_display_if wr_bus ();

    vga_digit_display #(
        .ORIGIN_X   (208),
        .ORIGIN_Y   (128),
        .SCALE_LOG2 (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .h_active   (h_active),
        .v_active   (v_active),
        .h_pos      (h_pos),
        .v_pos      (v_pos),
        .wr         (wr_bus),
        .frame_done (frame_done),
        .vga_rgb    (vga_rgb)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one word and wait (bounded) until it is accepted.
    task automatic push(input logic [3:0] d);
        int n;
        n = 0;
        wr_bus.wr_valid = 1'b1;
        wr_bus.wr_data  = d;
        while (wr_bus.wr_ready !== 1'b1 && n < 2000) begin
            step();
            n++;
        end
        if (n >= 2000) begin
            check("push_timeout", 32'd0, 32'd1);
        end
        step();
    endtask

    task automatic probe(input string tag, input logic ha, input int h, input int v,
                         input logic [7:0] exp);
        wr_bus.wr_valid = 1'b0;
        h_active = ha;
        h_pos    = 11'(h);
        v_pos    = 11'(v);
        step();
        step();
        check(tag, {24'd0, vga_rgb}, {24'd0, exp});
    endtask

    function automatic logic [3:0] frame2_pix(input int i);
        frame2_pix = (i == 29) ? 4'hA : 4'h0;
    endfunction

    initial begin
        wr_bus.wr_valid = 1'b0;
        wr_bus.wr_data  = 4'h0;

        // Reset held mid-frame with the raster inside the window.
        rst_n = 1'b0; h_active = 1'b1; v_active = 1'b1; h_pos = 11'd300; v_pos = 11'd200;
        repeat (3) step();
        check("rst_rgb", {24'd0, vga_rgb}, 32'h00);
        check("rst_frame_done", {31'd0, frame_done}, 32'd0);
        check("rst_wr_ready", {31'd0, wr_bus.wr_ready}, 32'd0);
        rst_n = 1'b1;
        step();
        check("rst_release_ready", {31'd0, wr_bus.wr_ready}, 32'd1);

        // Frame 1: all 0xF, then hold the first word of frame 2 under backpressure.
        for (int i = 0; i < 784; i++) push(4'hF);
        wr_bus.wr_valid = 1'b1;
        wr_bus.wr_data  = frame2_pix(0);
        for (int k = 0; k < 4; k++) begin
            check("bp_ready_low", {31'd0, wr_bus.wr_ready}, 32'd0);
            check("bp_no_done", {31'd0, frame_done}, 32'd0);
            step();
        end
        v_active = 1'b0;
        step();
        check("swap1_done", {31'd0, frame_done}, 32'd1);
        check("swap1_ready", {31'd0, wr_bus.wr_ready}, 32'd1);
        v_active = 1'b1;
        push(frame2_pix(0));
        check("swap1_pulse_width", {31'd0, frame_done}, 32'd0);
        for (int i = 1; i < 784; i++) push(frame2_pix(i));
        wr_bus.wr_valid = 1'b0;
        check("pending_ready_low", {31'd0, wr_bus.wr_ready}, 32'd0);

        // Frame 1 on screen: window edges, blanking, border.
        probe("f1_origin", 1'b1, 208, 128, 8'hFF);
        probe("f1_left_of_win", 1'b1, 207, 128, 8'h00);
        probe("f1_last_col", 1'b1, 431, 128, 8'hFF);
        probe("f1_right_of_win", 1'b1, 432, 128, 8'h00);
        probe("f1_last_row", 1'b1, 208, 351, 8'hFF);
        probe("f1_below_win", 1'b1, 208, 352, 8'h00);
        probe("blank_h_inactive", 1'b0, 208, 128, 8'h00);
`ifdef DIGIT_BORDER_EN
        probe("border_206", 1'b1, 206, 200, 8'hFF);
`else
        probe("border_206", 1'b1, 206, 200, 8'h00);
`endif
        probe("border_205", 1'b1, 205, 200, 8'h00);

        // Swap to frame 2 and check the scaled pixel 29.
        v_active = 1'b0;
        step();
        check("swap2_done", {31'd0, frame_done}, 32'd1);
        v_active = 1'b1;
        step();
        check("swap2_pulse_width", {31'd0, frame_done}, 32'd0);
        probe("scale_216_136", 1'b1, 216, 136, 8'hB6);
        probe("scale_223_143", 1'b1, 223, 143, 8'hB6);
        probe("scale_219_140", 1'b1, 219, 140, 8'hB6);
        probe("scale_224_136", 1'b1, 224, 136, 8'h00);
        probe("scale_215_136", 1'b1, 215, 136, 8'h00);
        probe("scale_216_144", 1'b1, 216, 144, 8'h00);

        // Frame 3 (0x8): last word coincides with a falling edge, so no swap yet.
        for (int i = 0; i < 783; i++) push(4'h8);
        wr_bus.wr_valid = 1'b1;
        wr_bus.wr_data  = 4'h8;
        v_active = 1'b0;
        step();
        check("coincide_no_done", {31'd0, frame_done}, 32'd0);
        check("coincide_ready_low", {31'd0, wr_bus.wr_ready}, 32'd0);
        wr_bus.wr_valid = 1'b0;
        v_active = 1'b1;
        step();
        check("coincide_still_no_done", {31'd0, frame_done}, 32'd0);
        probe("coincide_f2_shown", 1'b1, 216, 136, 8'hB6);
        v_active = 1'b0;
        step();
        check("swap3_done", {31'd0, frame_done}, 32'd1);
        v_active = 1'b1;
        probe("f3_origin", 1'b1, 208, 128, 8'h92);
        probe("f3_scaled", 1'b1, 216, 136, 8'h92);

        // Reset during a partial write with a visible pixel on the output.
        for (int i = 0; i < 5; i++) push(4'h1);
        rst_n = 1'b0;
        #1;
        check("midrst_rgb", {24'd0, vga_rgb}, 32'h00);
        check("midrst_frame_done", {31'd0, frame_done}, 32'd0);
        check("midrst_ready", {31'd0, wr_bus.wr_ready}, 32'd0);
        wr_bus.wr_valid = 1'b0;
        step();
        check("midrst_ready_held", {31'd0, wr_bus.wr_ready}, 32'd0);
        rst_n = 1'b1;
        step();
        check("midrst_release_ready", {31'd0, wr_bus.wr_ready}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
